instr_fetch_unit: RTL and testbench

Fetch stage of the Reptile-8 CPU, directly upstream of the control unit. Reads each 16-bit instruction as two bytes (high then low) from byte-wide instruction memory over a req/ack handshake, owns the program counter, and presents the latched instruction register with a one-cycle `ir_valid` strobe. Its `opcode` output is the control unit's `opcode` input. The control unit's fetch signal drives `fetch_start`; its PcLoad and jump target drive `pc_load` and `pc_load_val`.

---
 rtl/reptile_pkg.sv | 15 +
 rtl/pc_counter.sv | 22 ++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reptile_pkg.sv
// Shared Reptile-8 definitions: fetch state encoding and instruction field layout.
package reptile_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_REQ_HI = 2'd1,
        FETCH_REQ_LO = 2'd2
    } fetch_state_t;

    localparam int OPCODE_W = 3;
    localparam int INSTR_W  = 16;
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 13;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load has priority over increment, wraps modulo 2^ADDR_W.
module pc_counter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= '0;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + ADDR_W'(1);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Reptile-8 fetch stage: reads a 16-bit instruction as two bytes (high, low) over req/ack.
// Optional macro FETCH_TIMEOUT_EN adds an ack-wait timeout with a sticky fetch_err flag.
module instr_fetch_unit
    import reptile_pkg::*;
#(
    parameter int ADDR_W = 10
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_start,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   pc_load_val,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [7:0]          mem_rdata,
    output logic [INSTR_W-1:0]  ir,
    output logic [OPCODE_W-1:0] opcode,
    output logic                ir_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                fetch_err
);

    fetch_state_t      state, state_next;
    logic [7:0]        hi_byte;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_val;
    logic              hi_ack, lo_ack, abort;
    logic              pc_ld, pc_inc;
    logic [ADDR_W-1:0] pc_ld_val;

    assign hi_ack = (state == FETCH_REQ_HI) && mem_ack;
    assign lo_ack = (state == FETCH_REQ_LO) && mem_ack;
    assign opcode = ir[OPC_MSB:OPC_LSB];

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign abort = busy && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Counts unacknowledged request cycles; restarts whenever the state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state_next != state)
            wait_cnt <= '0;
        else if (busy)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_err <= 1'b0;
        else if (abort)
            fetch_err <= 1'b1;
    end
`else
    assign abort     = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FETCH_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE:   if (fetch_start) state_next = FETCH_REQ_HI;
            FETCH_REQ_HI: if (abort) state_next = FETCH_IDLE;
                          else if (mem_ack) state_next = FETCH_REQ_LO;
            FETCH_REQ_LO: if (abort || mem_ack) state_next = FETCH_IDLE;
            default:      state_next = FETCH_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state != FETCH_IDLE);
        busy     = (state != FETCH_IDLE);
        mem_addr = pc;
    end

    // A jump arriving in the completing cycle itself wins over an older pending target.
    always_comb begin
        pc_ld     = 1'b0;
        pc_inc    = 1'b0;
        pc_ld_val = pc_load_val;
        if (state == FETCH_IDLE && pc_load) begin
            pc_ld = 1'b1;
        end else if (hi_ack) begin
            pc_inc = 1'b1;
        end else if (lo_ack) begin
            if (pc_load) begin
                pc_ld = 1'b1;
            end else if (pend_valid) begin
                pc_ld     = 1'b1;
                pc_ld_val = pend_val;
            end else begin
                pc_inc = 1'b1;
            end
        end
    end

    pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_ld),
        .load_val (pc_ld_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte    <= 8'h00;
            ir         <= '0;
            ir_valid   <= 1'b0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
        end else begin
            ir_valid <= lo_ack;
            if (hi_ack)
                hi_byte <= mem_rdata;
            if (lo_ack)
                ir <= {hi_byte, mem_rdata};
            if (lo_ack || abort) begin
                pend_valid <= 1'b0;
            end else if (busy && pc_load) begin
                pend_valid <= 1'b1;
                pend_val   <= pc_load_val;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a byte memory responder of configurable ack latency.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              fetch_start;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic [15:0]       ir;
    logic [2:0]        opcode;
    logic              ir_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fetch_err;

    logic [7:0] mem [0:1023];
    int  ack_delay;
    bit  never_ack;
    int  ack_wait;
    int  vectors;
    int  miscompares;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .opcode      (opcode),
        .ir_valid    (ir_valid),
        .pc          (pc),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers after ack_delay wait cycles; inputs change mid-cycle, away from posedge.
    always @(negedge clk) begin
        if (mem_req && !never_ack && ack_wait >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            ack_wait  = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
            if (mem_req) ack_wait = ack_wait + 1;
            else         ack_wait = 0;
        end
    end

    task automatic run_fetch(input int max_cycles, output int vcyc);
        fetch_start = 1'b1;
        vcyc = -1;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            fetch_start = 1'b0;
            if (ir_valid && vcyc < 0) vcyc = c;
            if (vcyc >= 0) break;
        end
        fetch_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
        vectors++; if (pc !== 10'h000) begin miscompares++; $display("[TB] FAIL reset_pc: got %h want 000", pc); end
        vectors++; if (ir !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_ir: got %h want 0000", ir); end
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ir_valid: got %b want 0", ir_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fetch_err: got %b want 0", fetch_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        int v;
        ack_delay = 0;
        run_fetch(10, v);
        vectors++; if (v !== 3) begin miscompares++; $display("[TB] FAIL zw_valid_cycle: got %0d want 3", v); end
        vectors++; if (ir !== 16'hA123) begin miscompares++; $display("[TB] FAIL zw_ir: got %h want a123", ir); end
        vectors++; if (opcode !== 3'b101) begin miscompares++; $display("[TB] FAIL zw_opcode: got %b want 101", opcode); end
        vectors++; if (pc !== 10'h002) begin miscompares++; $display("[TB] FAIL zw_pc: got %h want 002", pc); end
        @(negedge clk);
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL zw_pulse: got %b want 0", ir_valid); end
        vectors++; if (ir !== 16'hA123) begin miscompares++; $display("[TB] FAIL zw_ir_hold: got %h want a123", ir); end
    endtask

    task automatic test_wait_states();
        logic [ADDR_W-1:0] exp_addr;
        ack_delay = 2;
        fetch_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            fetch_start = 1'b0;
            if (c <= 6) begin
                exp_addr = (c <= 3) ? 10'h002 : 10'h003;
                vectors++; if (mem_addr !== exp_addr) begin miscompares++; $display("[TB] FAIL ws_addr c%0d: got %h want %h", c, mem_addr, exp_addr); end
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ws_busy c%0d: got %b want 1", c, busy); end
                vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ws_early_valid c%0d: got %b want 0", c, ir_valid); end
            end else begin
                vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ws_valid c7: got %b want 1", ir_valid); end
                vectors++; if (ir !== 16'h5C77) begin miscompares++; $display("[TB] FAIL ws_ir: got %h want 5c77", ir); end
                vectors++; if (pc !== 10'h004) begin miscompares++; $display("[TB] FAIL ws_pc: got %h want 004", pc); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ws_idle: got %b want 0", busy); end
            end
        end
    endtask

    task automatic test_pc_load_wrap();
        int v;
        ack_delay = 0;
        pc_load = 1'b1;
        pc_load_val = 10'h3FE;
        @(negedge clk);
        pc_load = 1'b0;
        vectors++; if (pc !== 10'h3FE) begin miscompares++; $display("[TB] FAIL load_pc: got %h want 3fe", pc); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL load_no_fetch: got %b want 0", busy); end
        run_fetch(10, v);
        vectors++; if (v !== 3) begin miscompares++; $display("[TB] FAIL wrap_valid_cycle: got %0d want 3", v); end
        vectors++; if (ir !== 16'h1234) begin miscompares++; $display("[TB] FAIL wrap_ir: got %h want 1234", ir); end
        vectors++; if (opcode !== 3'b000) begin miscompares++; $display("[TB] FAIL wrap_opcode: got %b want 000", opcode); end
        vectors++; if (pc !== 10'h000) begin miscompares++; $display("[TB] FAIL wrap_pc: got %h want 000", pc); end
    endtask

    task automatic test_pending_jump();
        ack_delay = 2;
        fetch_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            fetch_start = (c == 2);
            pc_load     = (c == 5);
            pc_load_val = (c == 5) ? 10'h040 : 10'h155;
            if (c == 5) begin
                vectors++; if (mem_addr !== 10'h001) begin miscompares++; $display("[TB] FAIL pj_old_addr: got %h want 001", mem_addr); end
            end
            if (c == 7) begin
                vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL pj_valid: got %b want 1", ir_valid); end
                vectors++; if (ir !== 16'hA123) begin miscompares++; $display("[TB] FAIL pj_ir: got %h want a123", ir); end
                vectors++; if (pc !== 10'h040) begin miscompares++; $display("[TB] FAIL pj_pc: got %h want 040", pc); end
            end
        end
        fetch_start = 1'b0;
        pc_load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL pj_ignored_start: got %b want 0", mem_req); end
        end
        vectors++; if (pc !== 10'h040) begin miscompares++; $display("[TB] FAIL pj_pc_hold: got %h want 040", pc); end
    endtask

    task automatic test_back_to_back();
        ack_delay = 0;
        fetch_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            fetch_start = (c == 3);
            if (c == 3) begin
                vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_valid1: got %b want 1", ir_valid); end
                vectors++; if (ir !== 16'hE50F) begin miscompares++; $display("[TB] FAIL b2b_ir1: got %h want e50f", ir); end
                vectors++; if (opcode !== 3'b111) begin miscompares++; $display("[TB] FAIL b2b_opc1: got %b want 111", opcode); end
            end
            if (c == 4) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept: got %b want 1", busy); end
            end
            if (c == 6) begin
                vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_valid2: got %b want 1", ir_valid); end
                vectors++; if (ir !== 16'h3001) begin miscompares++; $display("[TB] FAIL b2b_ir2: got %h want 3001", ir); end
                vectors++; if (opcode !== 3'b001) begin miscompares++; $display("[TB] FAIL b2b_opc2: got %b want 001", opcode); end
                vectors++; if (pc !== 10'h044) begin miscompares++; $display("[TB] FAIL b2b_pc: got %h want 044", pc); end
            end
        end
        fetch_start = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        ack_delay = 2;
        fetch_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            fetch_start = 1'b0;
        end
        vectors++; if (mem_addr !== 10'h045) begin miscompares++; $display("[TB] FAIL rm_in_lo: got %h want 045", mem_addr); end
        rst_n = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_mem_req: got %b want 0", mem_req); end
        vectors++; if (pc !== 10'h000) begin miscompares++; $display("[TB] FAIL rm_pc: got %h want 000", pc); end
        vectors++; if (ir !== 16'h0000) begin miscompares++; $display("[TB] FAIL rm_ir: got %h want 0000", ir); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_busy: got %b want 0", busy); end
        @(negedge clk);
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_ir_valid: got %b want 0", ir_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_post_valid: got %b want 0", ir_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_post_busy: got %b want 0", busy); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        never_ack = 1'b1;
        fetch_start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            fetch_start = 1'b0;
            if (c <= 15) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL to_busy c%0d: got %b want 1", c, busy); end
            end else begin
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL to_idle: got %b want 0", busy); end
                vectors++; if (fetch_err !== 1'b1) begin miscompares++; $display("[TB] FAIL to_err: got %b want 1", fetch_err); end
                vectors++; if (pc !== 10'h000) begin miscompares++; $display("[TB] FAIL to_pc: got %h want 000", pc); end
                vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL to_valid: got %b want 0", ir_valid); end
            end
        end
        never_ack = 1'b0;
        @(negedge clk);
        vectors++; if (fetch_err !== 1'b1) begin miscompares++; $display("[TB] FAIL to_sticky: got %b want 1", fetch_err); end
    endtask
`else
    task automatic test_timeout();
        vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("[TB] FAIL no_timeout_err: got %b want 0", fetch_err); end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        ack_delay = 0;
        never_ack = 1'b0;
        ack_wait = 0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        fetch_start = 1'b0;
        pc_load = 1'b0;
        pc_load_val = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h000] = 8'hA1; mem[10'h001] = 8'h23;
        mem[10'h002] = 8'h5C; mem[10'h003] = 8'h77;
        mem[10'h3FE] = 8'h12; mem[10'h3FF] = 8'h34;
        mem[10'h040] = 8'hE5; mem[10'h041] = 8'h0F;
        mem[10'h042] = 8'h30; mem[10'h043] = 8'h01;
        mem[10'h044] = 8'hAB; mem[10'h045] = 8'hCD;
        @(negedge clk);
        $display("[TB] starting instr_fetch_unit tests");
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_pc_load_wrap();
        test_pending_jump();
        test_back_to_back();
        test_reset_mid_fetch();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
